dmi_req_sync: RTL and testbench



---
 rtl/dmi_pkg.sv | 8 +
 rtl/dmi_pulse_sync.sv | 23 ++
 rtl/dmi_req_sync.sv | 78 +++++++
 tb/tb_dmi_req_sync.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmi_pkg.sv
// dmi_pkg: shared FSM states, rd_status encodings and default address width for the DMI request bridge
package dmi_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  localparam logic [1:0] DMI_OK = 2'b00;
  localparam logic [1:0] DMI_FAIL = 2'b10;
  localparam logic [1:0] DMI_BUSY = 2'b11;
  localparam int DMI_AWIDTH = 7;
endpackage

// File: rtl/dmi_pulse_sync.sv
// dmi_pulse_sync: SYNC_STAGES-flop synchronizer with history flop turning a tck pulse into one registered clk-wide event (clk, rst_n, d -> pulse)
module dmi_pulse_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);
  logic [SYNC_STAGES-1:0] sync;
  logic hist;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      hist <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      hist <= sync[SYNC_STAGES-1];
      pulse <= sync[SYNC_STAGES-1] & ~hist;
    end
  end
endmodule

// File: rtl/dmi_req_sync.sv
// dmi_req_sync: tck-to-clk DMI request bridge (jtag pulses in, dmi_req/dmi_rsp handshake, rd_data/rd_status out); WAIT timeout built only with DMI_REQ_TMO_EN
module dmi_req_sync import dmi_pkg::*; #(
  parameter int AWIDTH = DMI_AWIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int TMO_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jtag_wr_en,
  input  logic              jtag_rd_en,
  input  logic [AWIDTH-1:0] jtag_addr,
  input  logic [31:0]       jtag_wdata,
  input  logic              jtag_dmi_reset,
  output logic              dmi_req_valid,
  input  logic              dmi_req_ready,
  output logic              dmi_req_wr,
  output logic [AWIDTH-1:0] dmi_req_addr,
  output logic [31:0]       dmi_req_wdata,
  input  logic              dmi_rsp_valid,
  input  logic [31:0]       dmi_rsp_rdata,
  output logic [31:0]       rd_data,
  output logic [1:0]        rd_status
);
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..4");
  end
  if (TMO_W < 2) begin : g_bad_tmo
    $error("TMO_W must be at least 2");
  end
  state_t state, state_n;
  logic wr_ev, rd_ev, clr_ev, req_ev, busy_ev, rsp_acc, tmo;
  dmi_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (.clk(clk), .rst_n(rst_n), .d(jtag_wr_en), .pulse(wr_ev));
  dmi_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (.clk(clk), .rst_n(rst_n), .d(jtag_rd_en), .pulse(rd_ev));
  dmi_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clr_sync (.clk(clk), .rst_n(rst_n), .d(jtag_dmi_reset), .pulse(clr_ev));
  assign req_ev = wr_ev | rd_ev;
  assign busy_ev = req_ev & (state != IDLE);
  assign rsp_acc = (state == WAIT) & dmi_rsp_valid;
  assign dmi_req_valid = state == REQ;
`ifdef DMI_REQ_TMO_EN
  logic [TMO_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
  end
  assign tmo = (state == WAIT) & ~dmi_rsp_valid & (&cnt);
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (req_ev ? REQ : IDLE) :
              state == REQ  ? (dmi_req_ready ? WAIT : REQ) :
              (rsp_acc | tmo) ? IDLE : WAIT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmi_req_wr <= 1'b0;
      dmi_req_addr <= '0;
      dmi_req_wdata <= '0;
      rd_data <= '0;
      rd_status <= DMI_OK;
    end else begin
      if (state == IDLE && req_ev) begin
        dmi_req_wr <= wr_ev;
        dmi_req_addr <= jtag_addr;
        dmi_req_wdata <= jtag_wdata;
      end
      if (rsp_acc && !dmi_req_wr) rd_data <= dmi_rsp_rdata;
      rd_status <= clr_ev ? DMI_OK :
                   busy_ev ? DMI_BUSY :
                   (tmo && rd_status != DMI_BUSY) ? DMI_FAIL : rd_status;
    end
  end
endmodule

// File: tb/tb_dmi_req_sync.sv
// tb_dmi_req_sync: directed self-checking bench for dmi_req_sync
module tb_dmi_req_sync;
  logic clk = 1'b0;
  logic rst_n;
  logic jtag_wr_en, jtag_rd_en, jtag_dmi_reset;
  logic [6:0] jtag_addr;
  logic [31:0] jtag_wdata;
  logic dmi_req_valid, dmi_req_ready, dmi_req_wr;
  logic [6:0] dmi_req_addr;
  logic [31:0] dmi_req_wdata;
  logic dmi_rsp_valid;
  logic [31:0] dmi_rsp_rdata, rd_data;
  logic [1:0] rd_status;
  int tests = 0;
  int fails = 0;
  dmi_req_sync #(.AWIDTH(7), .SYNC_STAGES(2), .TMO_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .jtag_wr_en(jtag_wr_en), .jtag_rd_en(jtag_rd_en),
    .jtag_addr(jtag_addr), .jtag_wdata(jtag_wdata),
    .jtag_dmi_reset(jtag_dmi_reset),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_req_wr(dmi_req_wr), .dmi_req_addr(dmi_req_addr),
    .dmi_req_wdata(dmi_req_wdata),
    .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_rdata(dmi_rsp_rdata),
    .rd_data(rd_data), .rd_status(rd_status)
  );
  always #5 clk = ~clk;
  task automatic launch(input logic wr, input logic [6:0] a, input logic [31:0] d, output int lat);
    jtag_addr = a;
    jtag_wdata = d;
    if (wr) jtag_wr_en = 1'b1;
    else jtag_rd_en = 1'b1;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 2) begin
        jtag_wr_en = 1'b0;
        jtag_rd_en = 1'b0;
      end
      if (dmi_req_valid) begin
        lat = n;
        break;
      end
    end
    jtag_wr_en = 1'b0;
    jtag_rd_en = 1'b0;
  endtask
  task automatic respond(input logic [31:0] d);
    dmi_rsp_valid = 1'b1;
    dmi_rsp_rdata = d;
    @(negedge clk);
    dmi_rsp_valid = 1'b0;
  endtask
  task automatic tpulse_clear();
    jtag_dmi_reset = 1'b1;
    repeat (2) @(negedge clk);
    jtag_dmi_reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic tpulse_rd_count(output int vcnt);
    vcnt = 0;
    jtag_rd_en = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 2) jtag_rd_en = 1'b0;
      if (dmi_req_valid) vcnt++;
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (dmi_req_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", dmi_req_valid); end
    tests++; if (dmi_req_wr !== 1'b0) begin fails++; $display("FAIL reset_wr: got %b want 0", dmi_req_wr); end
    tests++; if (dmi_req_addr !== 7'h00) begin fails++; $display("FAIL reset_addr: got %h want 00", dmi_req_addr); end
    tests++; if (dmi_req_wdata !== 32'h0) begin fails++; $display("FAIL reset_wdata: got %h want 0", dmi_req_wdata); end
    tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    tests++; if (rd_status !== 2'b00) begin fails++; $display("FAIL reset_status: got %b want 00", rd_status); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_read();
    int lat;
    launch(1'b0, 7'h11, 32'h0, lat);
    tests++; if (lat !== 4) begin fails++; $display("FAIL read_latency: got %0d want 4", lat); end
    tests++; if (dmi_req_wr !== 1'b0) begin fails++; $display("FAIL read_wr: got %b want 0", dmi_req_wr); end
    tests++; if (dmi_req_addr !== 7'h11) begin fails++; $display("FAIL read_addr: got %h want 11", dmi_req_addr); end
    @(negedge clk);
    tests++; if (dmi_req_valid !== 1'b0) begin fails++; $display("FAIL read_one_valid: got %b want 0", dmi_req_valid); end
    respond(32'hDEADBEEF);
    tests++; if (rd_data !== 32'hDEADBEEF) begin fails++; $display("FAIL read_data: got %h want deadbeef", rd_data); end
    tests++; if (rd_status !== 2'b00) begin fails++; $display("FAIL read_status: got %b want 00", rd_status); end
  endtask
  task automatic test_rsp_in_handshake();
    int lat;
    launch(1'b0, 7'h22, 32'h0, lat);
    dmi_rsp_valid = 1'b1;
    dmi_rsp_rdata = 32'h0BAD0BAD;
    @(negedge clk);
    dmi_rsp_valid = 1'b0;
    tests++; if (rd_data !== 32'hDEADBEEF) begin fails++; $display("FAIL early_rsp_ignored: got %h want deadbeef", rd_data); end
    respond(32'hCAFEF00D);
    tests++; if (rd_data !== 32'hCAFEF00D) begin fails++; $display("FAIL early_rsp_then_rsp: got %h want cafef00d", rd_data); end
  endtask
  task automatic test_write();
    int lat;
    launch(1'b1, 7'h10, 32'h1, lat);
    tests++; if (lat !== 4) begin fails++; $display("FAIL write_latency: got %0d want 4", lat); end
    tests++; if (dmi_req_wr !== 1'b1) begin fails++; $display("FAIL write_wr: got %b want 1", dmi_req_wr); end
    tests++; if (dmi_req_wdata !== 32'h1) begin fails++; $display("FAIL write_wdata: got %h want 1", dmi_req_wdata); end
    tests++; if (dmi_req_addr !== 7'h10) begin fails++; $display("FAIL write_addr: got %h want 10", dmi_req_addr); end
    @(negedge clk);
    respond(32'h12345678);
    tests++; if (rd_data !== 32'hCAFEF00D) begin fails++; $display("FAIL write_rd_data_kept: got %h want cafef00d", rd_data); end
  endtask
  task automatic test_busy();
    int lat, vcnt;
    launch(1'b0, 7'h05, 32'h0, lat);
    @(negedge clk);
    tpulse_rd_count(vcnt);
    tests++; if (rd_status !== 2'b11) begin fails++; $display("FAIL busy_status: got %b want 11", rd_status); end
    tests++; if (vcnt !== 0) begin fails++; $display("FAIL busy_no_extra_req: got %0d want 0", vcnt); end
    tpulse_clear();
    tests++; if (rd_status !== 2'b00) begin fails++; $display("FAIL busy_clear: got %b want 00", rd_status); end
    respond(32'h00000055);
    tests++; if (rd_data !== 32'h00000055) begin fails++; $display("FAIL busy_inflight_done: got %h want 00000055", rd_data); end
  endtask
  task automatic test_clear_wins();
    int lat, vcnt;
    launch(1'b0, 7'h06, 32'h0, lat);
    @(negedge clk);
    tpulse_rd_count(vcnt);
    tests++; if (rd_status !== 2'b11) begin fails++; $display("FAIL clrwin_pre_busy: got %b want 11", rd_status); end
    jtag_rd_en = 1'b1;
    jtag_dmi_reset = 1'b1;
    repeat (2) @(negedge clk);
    jtag_rd_en = 1'b0;
    jtag_dmi_reset = 1'b0;
    repeat (5) @(negedge clk);
    tests++; if (rd_status !== 2'b00) begin fails++; $display("FAIL clrwin_status: got %b want 00", rd_status); end
    respond(32'h00000066);
    tests++; if (rd_data !== 32'h00000066) begin fails++; $display("FAIL clrwin_rd_data: got %h want 00000066", rd_data); end
  endtask
  task automatic test_coincide();
    int vcnt;
    logic wr_seen;
    vcnt = 0;
    wr_seen = 1'b0;
    jtag_addr = 7'h33;
    jtag_wdata = 32'hA5A5A5A5;
    jtag_wr_en = 1'b1;
    jtag_rd_en = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 2) begin
        jtag_wr_en = 1'b0;
        jtag_rd_en = 1'b0;
      end
      if (dmi_req_valid) begin
        vcnt++;
        wr_seen = dmi_req_wr;
      end
    end
    tests++; if (vcnt !== 1) begin fails++; $display("FAIL coincide_req_count: got %0d want 1", vcnt); end
    tests++; if (wr_seen !== 1'b1) begin fails++; $display("FAIL coincide_wr_wins: got %b want 1", wr_seen); end
    tests++; if (rd_status !== 2'b00) begin fails++; $display("FAIL coincide_status: got %b want 00", rd_status); end
    respond(32'h00000077);
    tests++; if (rd_data !== 32'h00000066) begin fails++; $display("FAIL coincide_rd_data_kept: got %h want 00000066", rd_data); end
  endtask
  task automatic test_backpressure();
    int lat, held;
    dmi_req_ready = 1'b0;
    launch(1'b0, 7'h44, 32'h00000099, lat);
    held = 0;
    for (int i = 0; i < 5; i++) begin
      if (dmi_req_valid === 1'b1 && dmi_req_addr === 7'h44 && dmi_req_wdata === 32'h00000099) held++;
      @(negedge clk);
    end
    tests++; if (held !== 5) begin fails++; $display("FAIL bp_held_cycles: got %0d want 5", held); end
    tests++; if (dmi_req_valid !== 1'b1) begin fails++; $display("FAIL bp_valid_6th: got %b want 1", dmi_req_valid); end
    dmi_req_ready = 1'b1;
    @(negedge clk);
    tests++; if (dmi_req_valid !== 1'b0) begin fails++; $display("FAIL bp_handshake: got %b want 0", dmi_req_valid); end
    respond(32'h00000088);
    tests++; if (rd_data !== 32'h00000088) begin fails++; $display("FAIL bp_rd_data: got %h want 00000088", rd_data); end
  endtask
  task automatic test_timeout();
    int lat;
`ifdef DMI_REQ_TMO_EN
    int n_seen;
    launch(1'b0, 7'h55, 32'h0, lat);
    @(negedge clk);
    n_seen = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (rd_status === 2'b10) begin
        n_seen = n;
        break;
      end
    end
    tests++; if (n_seen !== 16) begin fails++; $display("FAIL tmo_cycles: got %0d want 16", n_seen); end
    tests++; if (rd_status !== 2'b10) begin fails++; $display("FAIL tmo_status: got %b want 10", rd_status); end
    launch(1'b0, 7'h56, 32'h0, lat);
    tests++; if (lat !== 4) begin fails++; $display("FAIL tmo_back_idle: got %0d want 4", lat); end
    @(negedge clk);
    respond(32'h00000099);
    tpulse_clear();
    tests++; if (rd_status !== 2'b00) begin fails++; $display("FAIL tmo_clear: got %b want 00", rd_status); end
`else
    int vcnt;
    launch(1'b0, 7'h55, 32'h0, lat);
    @(negedge clk);
    repeat (40) @(negedge clk);
    tests++; if (rd_status !== 2'b00) begin fails++; $display("FAIL notmo_status: got %b want 00", rd_status); end
    tpulse_rd_count(vcnt);
    tests++; if (rd_status !== 2'b11) begin fails++; $display("FAIL notmo_still_wait: got %b want 11", rd_status); end
    tpulse_clear();
    respond(32'h00000099);
    tests++; if (rd_data !== 32'h00000099) begin fails++; $display("FAIL notmo_rsp: got %h want 00000099", rd_data); end
`endif
  endtask
  task automatic test_reset_mid();
    int lat, vcnt;
    launch(1'b0, 7'h7A, 32'h0, lat);
    @(negedge clk);
    tpulse_rd_count(vcnt);
    rst_n = 1'b0;
    #1;
    tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL rstmid_rd_data: got %h want 0", rd_data); end
    tests++; if (rd_status !== 2'b00) begin fails++; $display("FAIL rstmid_status: got %b want 00", rd_status); end
    tests++; if (dmi_req_addr !== 7'h00) begin fails++; $display("FAIL rstmid_addr: got %h want 00", dmi_req_addr); end
    tests++; if (dmi_req_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid: got %b want 0", dmi_req_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    respond(32'hFFFF0000);
    @(negedge clk);
    tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL rstmid_late_rsp: got %h want 0", rd_data); end
    tests++; if (dmi_req_valid !== 1'b0) begin fails++; $display("FAIL rstmid_no_req: got %b want 0", dmi_req_valid); end
    launch(1'b0, 7'h12, 32'h0, lat);
    tests++; if (lat !== 4) begin fails++; $display("FAIL rstmid_idle_after: got %0d want 4", lat); end
  endtask
  initial begin
    rst_n = 1'b0;
    jtag_wr_en = 1'b0;
    jtag_rd_en = 1'b0;
    jtag_dmi_reset = 1'b0;
    jtag_addr = '0;
    jtag_wdata = '0;
    dmi_req_ready = 1'b1;
    dmi_rsp_valid = 1'b0;
    dmi_rsp_rdata = '0;
    test_reset();
    test_read();
    test_rsp_in_handshake();
    test_write();
    test_busy();
    test_clear_wins();
    test_coincide();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
